// File: rtl/uart_tx_scheduler_if.sv
// Requester-side bus of the UART transmit scheduler: per-requester request,
// byte and capture acknowledge.
interface uart_tx_scheduler_if #(
  parameter int N = 2
) ();
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   ack;

  modport master (output req, output req_data, input ack);
  modport slave  (input req, input req_data, output ack);
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between N requesters,
// with frame tracking through TBR and an inter-frame gap counted in baud ticks.
module uart_tx_scheduler #(
  parameter int N         = 2,
  parameter int GAP_TICKS = 1,
  parameter int IDW       = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_tx_scheduler_if.slave   rq,
  input  logic                 baud_tick,
  input  logic                 tbr,
  output logic                 tx_enable,
  output logic [7:0]           tx_data,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 tx_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, GAP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] win;
  logic           win_vld;
  logic [3:0]     gap_cnt, gap_cnt_nxt;
  logic [N-1:0]   ack_q, ack_nxt;
  logic           grant_p0;
  logic           done_p0;
  int             idx;

  function automatic logic [IDW-1:0] ptr_after(input logic [IDW-1:0] w);
    if (int'(w) == N - 1) return '0;
    return w + 1'b1;
  endfunction

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % N;
      if (rq.req[idx[IDW-1:0]]) begin
        win     = idx[IDW-1:0];
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    grant_p0    = 1'b0;
    done_p0     = 1'b0;
    ack_nxt     = '0;
    case (state)
      IDLE: begin
        if (win_vld && tbr) begin
          grant_p0  = 1'b1;
          ack_nxt   = {{(N-1){1'b0}}, 1'b1} << win;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (baud_tick) state_nxt = BUSY;
      end
      BUSY: begin
        if (tbr) begin
          done_p0 = 1'b1;
          if (GAP_TICKS == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt   = GAP;
            gap_cnt_nxt = 4'(GAP_TICKS);
          end
        end
      end
      GAP: begin
        if (baud_tick) begin
          gap_cnt_nxt = gap_cnt - 4'd1;
          if (gap_cnt <= 4'd1) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // p0 -> registered: capture of the winning byte and one-cycle pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      gap_cnt  <= '0;
      ack_q    <= '0;
      tx_done  <= 1'b0;
      tx_data  <= 8'h00;
      grant_id <= '0;
    end else begin
      gap_cnt <= gap_cnt_nxt;
      ack_q   <= ack_nxt;
      tx_done <= done_p0;
      if (grant_p0) begin
        tx_data  <= rq.req_data[{win, 3'b000} +: 8];
        grant_id <= win;
        rr_ptr   <= ptr_after(win);
      end
    end
  end

  assign rq.ack    = ack_q;
  assign tx_enable = (state == ISSUE);
  assign busy      = (state != IDLE);

endmodule
